// File: rtl/trigger_capture_ctrl.sv
// rtl/trigger_capture_ctrl.sv - capture sequencer: arm, pre-fill, trigger wait, post count, done
// Optional TRIGGER_CAPTURE_EARLY_EN: honour a trigger event while still in PRE.
module trigger_capture_ctrl #(
  parameter int BAW = 6,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int MAW = 12
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SEW-1:0] sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  output logic           mem_wen,
  output logic [MAW-1:0] mem_waddr,
  output logic [SDW-1:0] mem_wdata,
  output logic [2:0]     sts_state,
  output logic [MAW-1:0] sts_trg_adr,
  output logic           sts_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [MAW-1:0] cfg_pre_q, cfg_pre_d, cfg_post_q, cfg_post_d;
  logic [MAW-1:0] wptr_q, wptr_d, cnt_q, cnt_d, trg_adr_q, trg_adr_d;
  logic [MAW-1:0] waddr_q, waddr_d;
  logic [SDW-1:0] wdata_q, wdata_d;
  logic           wen_q, wen_d, done_q, done_d;

  logic           ctrl_wr, arm, abort, capturing, trig_ok;
  logic [MAW:0]   cnt_inc;
  logic           unused_bits;

  assign bus_wready  = 1'b1;
  assign sti_tready  = 1'b1;
  assign unused_bits = ^{bus_wdata, sti_tevent};

  assign ctrl_wr   = bus_wvalid && (bus_waddr == BAW'(0));
  assign arm       = ctrl_wr && bus_wdata[0];
  assign abort     = ctrl_wr && bus_wdata[1];
  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  // One counter serves both the pre-fill and the post-trigger phase; it restarts on each phase entry.
  assign cnt_inc   = {1'b0, cnt_q} + (MAW+1)'(1);

`ifdef TRIGGER_CAPTURE_EARLY_EN
  assign trig_ok = sti_tevent[0] && ((state_q == S_WAIT) || (state_q == S_PRE));
`else
  assign trig_ok = sti_tevent[0] && (state_q == S_WAIT);
`endif

  always_comb begin
    state_d    = state_q;
    cfg_pre_d  = cfg_pre_q;
    cfg_post_d = cfg_post_q;
    wptr_d     = wptr_q;
    cnt_d      = cnt_q;
    trg_adr_d  = trg_adr_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;

    if (bus_wvalid && (bus_waddr == BAW'(1))) cfg_pre_d  = bus_wdata[MAW-1:0];
    if (bus_wvalid && (bus_waddr == BAW'(2))) cfg_post_d = bus_wdata[MAW-1:0];

    if (abort) begin
      state_d = S_IDLE;
    end else if (capturing) begin
      if (sti_tvalid) begin
        wen_d   = 1'b1;
        waddr_d = wptr_q;
        wdata_d = sti_tdata;
        wptr_d  = wptr_q + MAW'(1);
        cnt_d   = cnt_inc[MAW-1:0];
        if (trig_ok) begin
          trg_adr_d = wptr_q;
          cnt_d     = '0;
          state_d   = (cfg_post_q == '0) ? S_DONE : S_POST;
        end else if ((state_q == S_PRE) && (cnt_inc >= {1'b0, cfg_pre_q})) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if ((state_q == S_POST) && (cnt_inc >= {1'b0, cfg_post_q})) begin
          state_d = S_DONE;
        end
      end
    end else if (arm) begin
      wptr_d  = '0;
      cnt_d   = '0;
      state_d = (cfg_pre_q == '0) ? S_WAIT : S_PRE;
    end

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cfg_pre_q  <= '0;
      cfg_post_q <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      trg_adr_q  <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_pre_q  <= cfg_pre_d;
      cfg_post_q <= cfg_post_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      trg_adr_q  <= trg_adr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
    end
  end

  assign mem_wen     = wen_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign sts_state   = state_q;
  assign sts_trg_adr = trg_adr_q;
  assign sts_done    = done_q;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// tb/tb_trigger_capture_ctrl.sv - randomized bench for trigger_capture_ctrl against a capture model
module tb_trigger_capture_ctrl;
  localparam int BAW = 6, BDW = 32, SDW = 32, SEW = 2, MAW = 4;
  localparam int DEPTH = 1 << MAW;
  localparam int P_IDLE = 0, P_PRE = 1, P_WAIT = 2, P_POST = 3, P_DONE = 4;
`ifdef TRIGGER_CAPTURE_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0, rst = 1'b1;
  logic           bus_wready, bus_wvalid = 1'b0;
  logic [BAW-1:0] bus_waddr = '0;
  logic [BDW-1:0] bus_wdata = '0;
  logic           sti_tready, sti_tvalid = 1'b0;
  logic [SEW-1:0] sti_tevent = '0;
  logic [SDW-1:0] sti_tdata = '0;
  logic           mem_wen, sts_done;
  logic [MAW-1:0] mem_waddr, sts_trg_adr;
  logic [SDW-1:0] mem_wdata;
  logic [2:0]     sts_state;

  trigger_capture_ctrl #(.BAW(BAW), .BDW(BDW), .SDW(SDW), .SEW(SEW), .MAW(MAW)) dut (
    .clk(clk), .rst(rst),
    .bus_wready(bus_wready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
    .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent), .sti_tdata(sti_tdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .sts_state(sts_state), .sts_trg_adr(sts_trg_adr), .sts_done(sts_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Capture model: phase, samples taken since arm / since trigger, next RAM slot.
  int          m_phase, m_slot, m_pre_taken, m_post_taken, m_trg, m_cfg_pre, m_cfg_post;
  bit          exp_wen, exp_done;
  int          exp_addr;
  logic [31:0] exp_data;

  task automatic model_reset();
    m_phase = P_IDLE; m_slot = 0; m_pre_taken = 0; m_post_taken = 0; m_trg = 0;
    m_cfg_pre = 0; m_cfg_post = 0; exp_wen = 0; exp_done = 0; exp_addr = 0; exp_data = 0;
  endtask

  task automatic model_step(input bit wv, input int wa, input logic [31:0] wd,
                            input bit tv, input bit trg, input logic [31:0] td);
    int  prev;
    bit  arm, abort;
    prev    = m_phase;
    arm     = wv && (wa == 0) && wd[0];
    abort   = wv && (wa == 0) && wd[1];
    exp_wen = 0;
    if (abort) m_phase = P_IDLE;
    else if (m_phase == P_PRE || m_phase == P_WAIT || m_phase == P_POST) begin
      if (tv) begin
        exp_wen  = 1; exp_addr = m_slot; exp_data = td;
        m_slot   = (m_slot + 1) % DEPTH;
        if (trg && (m_phase == P_WAIT || (EARLY && m_phase == P_PRE))) begin
          m_trg = exp_addr; m_post_taken = 0;
          m_phase = (m_cfg_post == 0) ? P_DONE : P_POST;
        end else if (m_phase == P_PRE) begin
          m_pre_taken++;
          if (m_pre_taken == m_cfg_pre) m_phase = P_WAIT;
        end else if (m_phase == P_POST) begin
          m_post_taken++;
          if (m_post_taken == m_cfg_post) m_phase = P_DONE;
        end
      end
    end else if (arm) begin
      m_slot = 0; m_pre_taken = 0;
      m_phase = (m_cfg_pre == 0) ? P_WAIT : P_PRE;
    end
    if (wv && wa == 1) m_cfg_pre  = int'(wd) & (DEPTH - 1);
    if (wv && wa == 2) m_cfg_post = int'(wd) & (DEPTH - 1);
    exp_done = (m_phase == P_DONE) && (prev != P_DONE);
  endtask

  task automatic check_outputs();
    chk("state", 32'(sts_state), 32'(m_phase));
    chk("wen", 32'(mem_wen), 32'(exp_wen));
    if (exp_wen) begin
      chk("waddr", 32'(mem_waddr), 32'(exp_addr));
      chk("wdata", mem_wdata, exp_data);
    end
    chk("trg_adr", 32'(sts_trg_adr), 32'(m_trg));
    chk("done", 32'(sts_done), 32'(exp_done));
  endtask

  task automatic step(input bit wv, input int wa, input logic [31:0] wd,
                      input bit tv, input logic [1:0] ev, input logic [31:0] td);
    @(negedge clk);
    check_outputs();
    bus_wvalid = wv; bus_waddr = BAW'(wa); bus_wdata = wd;
    sti_tvalid = tv; sti_tevent = ev; sti_tdata = td;
    model_step(wv, wa, wd, tv, ev[0], td);
  endtask

  task automatic check_reset_values();
    chk("rst_state", 32'(sts_state), 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_trg", 32'(sts_trg_adr), 32'd0);
    chk("rst_done", 32'(sts_done), 32'd0);
    chk("wready", 32'(bus_wready), 32'd1);
    chk("tready", 32'(sti_tready), 32'd1);
  endtask

  initial begin
    logic [31:0] wd;
    int r, wa, guard;
    bit wv;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Zero pre/post: first triggered sample lands at 0 and DONE follows immediately.
    step(1, 1, 32'd0, 0, 2'b00, 0);
    step(1, 2, 32'd0, 0, 2'b00, 0);
    step(1, 0, 32'd1, 1, 2'b01, 32'h11);
    step(0, 0, 0, 1, 2'b01, 32'hA5A5_0001);
    step(0, 0, 0, 1, 2'b00, 32'h22);
    step(0, 0, 0, 0, 2'b00, 0);

    // Pre=4/post=3 with trigger at sample 9, then trigger at sample 1 (early-path check).
    step(1, 1, 32'd4, 0, 2'b00, 0);
    step(1, 2, 32'd3, 0, 2'b00, 0);
    step(1, 0, 32'd1, 0, 2'b00, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, (i == 9) ? 2'b01 : 2'b00, 32'(i));
    step(1, 0, 32'd1, 0, 2'b00, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, (i == 1) ? 2'b01 : 2'b00, 32'(100 + i));
    step(1, 0, 32'd2, 1, 2'b00, 32'h33);
    step(1, 0, 32'd3, 1, 2'b01, 32'h44);
    step(0, 0, 0, 1, 2'b01, 32'h55);

    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 63); wv = 0; wa = 0; wd = $urandom;
      if (r < 3) begin wv = 1; wd[1:0] = 2'b01; end
      else if (r == 3) begin wv = 1; wd[1:0] = 2'b10; end
      else if (r == 4) begin wv = 1; wd[1:0] = 2'b11; end
      else if ((r == 5 || r == 6) && (m_phase == P_IDLE || m_phase == P_DONE)) begin
        wv = 1; wa = r - 4;
      end else if (r == 7) begin wv = 1; wa = $urandom_range(3, 63); end
      else if (r == 8) begin wv = 1; wd[1:0] = 2'b00; end
      step(wv, wa, wd, ($urandom_range(0, 3) != 0),
           {1'($urandom), ($urandom_range(0, 11) == 0)}, $urandom);
    end

    // Reset in the middle of WAIT, then a fresh capture must start at address 0.
    step(1, 1, 32'd2, 0, 2'b00, 0);
    step(1, 2, 32'd5, 0, 2'b00, 0);
    step(1, 0, 32'd1, 0, 2'b00, 0);
    guard = 0;
    while (m_phase != P_WAIT && guard < 50) begin
      step(0, 0, 0, 1, 2'b00, $urandom);
      guard++;
    end
    chk("reach_wait", 32'(m_phase), 32'(P_WAIT));
    step(0, 0, 0, 1, 2'b00, $urandom);
    @(negedge clk);
    check_outputs();
    bus_wvalid = 0; sti_tvalid = 0; sti_tevent = '0;
    rst = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 0, 32'd1, 0, 2'b00, 0);
    step(0, 0, 0, 1, 2'b01, 32'hBEEF);
    step(0, 0, 0, 0, 2'b00, 0);
    step(0, 0, 0, 0, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
